// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with clock inhibit, request-to-send, odd parity and ack check.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS_SETUP, SEND, ACK, WAIT_IDLE, FINISH} state_t;
  state_t state_q, state_d;
  logic [2:0] clk_s_q, clk_s_d;
  logic [1:0] dat_s_q, dat_s_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0] bit_q, bit_d;
  logic [8:0] sh_q, sh_d;
  logic clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic fall, fail, line_d;
  // clk_s_q[1] is the synchronized clock, clk_s_q[2] its previous value
  assign fall = clk_s_q[2] & ~clk_s_q[1];
  always_comb begin
    clk_s_d = {clk_s_q[1:0], ps2_clk_in};
    dat_s_d = {dat_s_q[0], ps2_data_in};
    state_d = state_q;
    inh_d = inh_q;
    timer_d = timer_q;
    bit_d = bit_q;
    sh_d = sh_q;
    line_d = data_oe_q;
    fail = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = INHIBIT;
        inh_d = '0;
        sh_d = {~^data, data};
      end
      INHIBIT: begin
        inh_d = inh_q + 1'b1;
        state_d = inh_q == IW'(INHIBIT_CYCLES - 1) ? RTS_SETUP : INHIBIT;
      end
      RTS_SETUP: begin
        state_d = SEND;
        bit_d = '0;
        timer_d = '0;
      end
      SEND, ACK, WAIT_IDLE: begin
        timer_d = fall ? '0 : timer_q + 1'b1;
        if (state_q == SEND && fall) begin
          bit_d = bit_q + 1'b1;
          sh_d = sh_q >> 1;
          line_d = bit_q < 4'd9 ? ~sh_q[0] : 1'b0;
          state_d = bit_q == 4'd9 ? ACK : SEND;
        end
        if (state_q == ACK && fall) begin
          state_d = dat_s_q[1] ? FINISH : WAIT_IDLE;
          fail = dat_s_q[1];
        end
        if (state_q == WAIT_IDLE && clk_s_q[1] && dat_s_q[1]) state_d = FINISH;
        if (!fall && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FINISH;
          fail = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    clk_oe_d = state_d == INHIBIT || state_d == RTS_SETUP;
    data_oe_d = state_d == RTS_SETUP || (state_d == SEND && line_d);
    busy_d = !(state_d == IDLE || state_d == FINISH);
    done_d = state_d == FINISH;
    err_d = fail;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clk_s_q <= '1;
      dat_s_q <= '1;
      inh_q <= '0;
      timer_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_s_q <= clk_s_d;
      dat_s_q <= dat_s_d;
      inh_q <= inh_d;
      timer_q <= timer_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      clk_oe_q <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven frames against a 40-cycle-period PS/2 device model, plus reset-abort sequence.
module tb_ps2_host_tx;
  localparam int INH = 10;
  localparam int TMO = 200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] data = 8'h00;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, busy, done, err;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int repulse_at = 0;
  logic ack_bit = 1'b0;
  logic done_err = 1'b0;
  logic [2:0] done_lines = 3'b000;
  logic [9:0] obs;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data(data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // open-collector wires: either side can pull low
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) begin
    done_cnt <= done_cnt + 1;
    done_cyc <= cyc;
    done_err <= err;
    done_lines <= {busy, ps2_clk_oe, ps2_data_oe};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] d;
    logic       ack;
    int         nf;
    int         rp;
    logic [9:0] exp_oe;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    data = ~d;
    chk("inhibit_first", 16'({busy, ps2_clk_oe, ps2_data_oe}), 16'h6);
    repeat (INH - 1) @(negedge clk);
    chk("inhibit_last", 16'({busy, ps2_clk_oe, ps2_data_oe}), 16'h6);
    @(negedge clk);
    chk("rts_setup", 16'({busy, ps2_clk_oe, ps2_data_oe}), 16'h7);
    @(negedge clk);
    chk("clk_release", 16'({busy, ps2_clk_oe, ps2_data_oe}), 16'h5);
  endtask

  task automatic dev_falls(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      if (k == 11) dev_data = ack_bit;
      @(negedge clk);
      dev_clk = 1'b0;
      fall_cyc = cyc;
      repeat (19) @(negedge clk);
      if (k <= 10) obs[k-1] = ps2_data_oe;
      if (k == repulse_at) begin
        data = 8'h12;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      @(negedge clk);
      dev_clk = 1'b1;
      dev_data = 1'b1;
      repeat (19) @(negedge clk);
    end
  endtask

  task automatic wait_done(input int base, input logic exp_err);
    int n = 0;
    while (done_cnt == base && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 16'(done_cnt - base), 16'h1);
    chk("err", 16'(done_err), 16'(exp_err));
    chk("lines_at_done", 16'(done_lines), 16'h0);
    repeat (30) @(negedge clk);
    chk("single_done", 16'(done_cnt - base), 16'h1);
  endtask

  task automatic run_frame(input vec_t v);
    int base = done_cnt;
    logic [9:0] m = v.nf >= 10 ? 10'h3FF : 10'((1 << v.nf) - 1);
    ack_bit = v.ack;
    repulse_at = v.rp;
    obs = '0;
    start_frame(v.d);
    repeat (10) @(negedge clk);
    dev_falls(1, v.nf);
    wait_done(base, v.exp_err);
    chk("frame_bits", 16'(obs & m), 16'(v.exp_oe & m));
    if (v.nf < 11) begin
      checks++;
      if (done_cyc - fall_cyc < 195 || done_cyc - fall_cyc > 215) begin
        errors++;
        $display("FAIL timeout_latency: got %0d cycles required 195..215", done_cyc - fall_cyc);
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    int base;
    // exp_oe[k-1] = ps2_data_oe after fall k: ~data bits, ~parity, released stop
    vecs[0] = '{8'hED, 1'b0, 11, 0, 10'h012, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 11, 0, 10'h0FF, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 11, 0, 10'h000, 1'b0};
    vecs[3] = '{8'h5A, 1'b1, 11, 0, 10'h0A5, 1'b1};
    vecs[4] = '{8'h3A, 1'b0, 4, 0, 10'h0C5, 1'b1};
    vecs[5] = '{8'h96, 1'b0, 11, 3, 10'h069, 1'b0};
    repeat (3) @(negedge clk);
    chk("reset_outputs", 16'({ps2_clk_oe, ps2_data_oe, busy, done, err}), 16'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outputs", 16'({ps2_clk_oe, ps2_data_oe, busy, done, err}), 16'h0);
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);
    // abort at fall 6 of 0x1C: bit5=0 so data is being pulled low when reset hits
    base = done_cnt;
    ack_bit = 1'b0;
    repulse_at = 0;
    start_frame(8'h1C);
    repeat (10) @(negedge clk);
    dev_falls(1, 5);
    @(negedge clk);
    dev_clk = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset", 16'({busy, ps2_clk_oe, ps2_data_oe}), 16'h5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_abort", 16'({busy, ps2_clk_oe, ps2_data_oe, done, err}), 16'h0);
    dev_clk = 1'b1;
    repeat (300) @(negedge clk);
    chk("no_done_after_abort", 16'(done_cnt - base), 16'h0);
    run_frame('{8'hF4, 1'b0, 11, 0, 10'h10B, 1'b0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the attached keyboard over the open-collector PS/2 clock/data pair. It is the outbound counterpart of the keyboard scan-code receive path. It performs clock inhibit, request-to-send, device-clocked bit shifting with odd parity, and acknowledge check. It sits between the command-generating logic and the PS/2 pin pads; the pads implement `oe=1` as "pull low", `oe=0` as "release".

## Interface
- `INHIBIT_CYCLES`, default 5000. Number of `clk` cycles PS/2 clock is held low before request-to-send; 100 µs at 50 MHz.
- `TIMEOUT_CYCLES`, default 1_000_000. Maximum `clk` cycles allowed between consecutive device clock falling edges; 20 ms at 50 MHz.
- `clk` in 1: system clock; one clock domain only.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to send `data`; sampled only in IDLE.
- `data` in 8: command byte, captured on accepted `start`.
- `ps2_clk_in` in 1: raw PS/2 clock pin level (asynchronous).
- `ps2_data_in` in 1: raw PS/2 data pin level (asynchronous).
- `ps2_clk_oe` out 1: 1 = pull PS/2 clock low.
- `ps2_data_oe` out 1: 1 = pull PS/2 data low.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done` out 1: one-cycle pulse at end of every transaction (success or failure).
- `err` out 1: valid only with `done`; 1 = no ack or timeout.

## Operation
- Both pin inputs pass through a 2-FF synchronizer. A falling edge (`fall`) is detected from the synchronized clock and its previous value. `fall` is seen 3 `clk` cycles after the pin transition.
- On accepted `start`, the block latches `data` into a shift register and computes parity `p = ~^data` (odd parity).
- States:
  - **IDLE**: all outputs 0. `start=1` -> INHIBIT, timer cleared.
  - **INHIBIT**: `ps2_clk_oe=1`, `ps2_data_oe=0` for exactly `INHIBIT_CYCLES` cycles -> RTS_SETUP.
  - **RTS_SETUP** (1 cycle): `ps2_clk_oe=1`, `ps2_data_oe=1` (start bit 0 driven before clock release) -> SEND; bit counter=0, timer=0.
  - **SEND**: `ps2_clk_oe=0`. On each `fall`, the counter increments, the timer clears, and the line is updated:
    - falls 1–8 drive data bits d0..d7, LSB first, with `ps2_data_oe = ~bit`;
    - fall 9 drives parity `p`;
    - fall 10 releases data (stop bit, `ps2_data_oe=0`) -> ACK.
  - **ACK**: on next `fall`, sample synchronized data. 0 = acknowledged -> WAIT_IDLE; 1 -> FINISH with err.
  - **WAIT_IDLE**: wait until synchronized clock and data are both 1 -> FINISH with err=0.
  - **FINISH** (1 cycle): `done=1`, `err` as recorded -> IDLE.
- Timeout: in SEND, ACK or WAIT_IDLE, the timer counts every cycle without `fall`. On reaching `TIMEOUT_CYCLES`, the block releases both lines -> FINISH with err=1.
- `start` while not IDLE is ignored; `data` changes after capture have no effect.
- `reset` in any state forces IDLE next cycle with both `oe` released, and clears `busy`, `done`, `err`, counters and timer. No `done` is issued for the aborted frame.

## Timing
- Reset values: `ps2_clk_oe=0`, `ps2_data_oe=0`, `busy=0`, `done=0`, `err=0`.
- `start` sampled high at edge T. From T+1, `busy=1` and `ps2_clk_oe=1`. At T+1+`INHIBIT_CYCLES`, `ps2_data_oe=1` with clock still low. At T+2+`INHIBIT_CYCLES`, `ps2_clk_oe=0`.
- All outputs are registered. Each data-line update happens on the cycle following detection of `fall`, i.e. while the device clock is low.
- `done`/`err` are asserted for exactly one cycle. `busy` is 0 in that same cycle, and a new `start` is accepted there is none — IDLE is entered the following cycle, where the next `start` is accepted.
- Timer width is sized by `$clog2(TIMEOUT_CYCLES+1)`; inhibit counter by `$clog2(INHIBIT_CYCLES+1)`.

## Test plan
All scenarios use `INHIBIT_CYCLES=10`, `TIMEOUT_CYCLES=200`, and a device model that clocks at 40-cycle period.
- `data=0xED`, `start` pulse -> clock held low 10 cycles; data low before release; bits on falls 1–8 = 1,0,1,1,0,1,1,1; parity 1; stop released; device ack 0 -> `done=1`, `err=0`.
- `data=0x00` -> all eight bits 0, parity 1. `data=0xFF` -> parity 1. Check `ps2_data_oe` per bit accordingly.
- Device holds data high at fall 11 (no ack) -> `done=1`, `err=1`; both `oe` 0.
- Device stops clocking after fall 4 -> 200 cycles later `done=1`, `err=1`; lines released.
- `start` re-pulsed mid-frame with `data=0x12` -> ignored; frame bits still match the original byte; a single `done` pulse.
- `reset` asserted at fall 6 -> next cycle both `oe`=0 and `busy`=0; no `done` pulse. A subsequent `start` with 0xF4 completes normally.
